// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU. Holds EX via stallreq_o
// and returns {remainder, quotient} with ready_o.
module div_seq #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] opdata1_i,
    input  logic [DATA_W-1:0] opdata2_i,
    input  logic              start_i,
    input  logic              annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic              ready_o,
    output logic              busy_o,
    output logic              stallreq_o
);

    typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   quot, rem, dvsr;
    logic                neg_q, neg_r;
    logic [2*DATA_W-1:0] result;
    logic                ready;

    logic [DATA_W-1:0]   op1_mag, op2_mag;
    logic [DATA_W:0]     shifted, diff;
    logic [DATA_W-1:0]   quot_n, rem_n, quot_fix, rem_fix;
    logic                go, last_iter;

    assign go        = start_i & ~annul_i;
    assign last_iter = (cnt == CNT_W'(DATA_W - 1));

    assign op1_mag = (signed_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign op2_mag = (signed_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

    // The full remainder takes part in the shift: with an unsigned divisor
    // above 2**(DATA_W-1) the partial remainder can have its MSB set.
    assign shifted = {rem, quot[DATA_W-1]};
    assign diff    = shifted - {1'b0, dvsr};

    always_comb begin
        rem_n  = shifted[DATA_W-1:0];
        quot_n = {quot[DATA_W-2:0], 1'b0};
        if (!diff[DATA_W]) begin
            rem_n  = diff[DATA_W-1:0];
            quot_n = {quot[DATA_W-2:0], 1'b1};
        end
    end

    assign quot_fix = neg_q ? -quot_n : quot_n;
    assign rem_fix  = neg_r ? -rem_n  : rem_n;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (go) state_n = (opdata2_i == '0) ? S_BYZERO : S_ON;
            end
            S_BYZERO: state_n = annul_i ? S_IDLE : S_END;
            S_ON: begin
                if (annul_i)        state_n = S_IDLE;
                else if (last_iter) state_n = S_END;
            end
            S_END: begin
                // Leave only once ready_o has actually been presented to EX.
                if (annul_i || (!start_i && ready)) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            quot   <= '0;
            rem    <= '0;
            dvsr   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= '0;
            ready  <= 1'b0;
        end else begin
            ready <= (state == S_END) && (state_n == S_END);
            case (state)
                S_IDLE: begin
                    if (go && opdata2_i != '0) begin
                        cnt   <= '0;
                        quot  <= op1_mag;
                        rem   <= '0;
                        dvsr  <= op2_mag;
                        neg_q <= signed_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                        neg_r <= signed_i & opdata1_i[DATA_W-1];
                    end
                end
                S_BYZERO: begin
                    if (!annul_i) result <= '0;
                end
                S_ON: begin
                    if (!annul_i) begin
                        cnt  <= cnt + 1'b1;
                        quot <= quot_n;
                        rem  <= rem_n;
                        if (last_iter) result <= {rem_fix, quot_fix};
                    end
                end
                default: ;
            endcase
        end
    end

    assign result_o   = result;
    assign ready_o    = ready;
    assign busy_o     = (state == S_BYZERO) || (state == S_ON);
    assign stallreq_o = start_i & ~ready & ~annul_i;

endmodule

// File: tb/tb_div_seq.sv
// Directed and randomized checks of div_seq: latency, stall window, signed
// fix-up, divide-by-zero, annul, mid-division reset and result hold.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_i;
    logic [31:0] opdata1_i, opdata2_i;
    logic        start_i, annul_i;
    logic [63:0] result_o;
    logic        ready_o, busy_o, stallreq_o;

    int checks = 0;
    int fails  = 0;

    div_seq #(.DATA_W(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .signed_i  (signed_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .start_i   (start_i),
        .annul_i   (annul_i),
        .result_o  (result_o),
        .ready_o   (ready_o),
        .busy_o    (busy_o),
        .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    // Starts an operation and waits (bounded) for ready_o; lat counts edges
    // after the sampling edge E0, -1 on timeout. start_i is left high.
    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           output logic [63:0] res, output int lat,
                           output int stalls, output int busys);
        @(negedge clk);
        signed_i = s; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
        lat = -1; stalls = 0; busys = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (ready_o) begin lat = n - 1; break; end
            if (stallreq_o) stalls++;
            if (busy_o) busys++;
        end
        res = result_o;
    endtask

    task automatic release_start();
        start_i = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb, q, r;
        ma = (s && a[31]) ? 32'd0 - a : a;
        mb = (s && b[31]) ? 32'd0 - b : b;
        q = ma / mb;
        r = ma % mb;
        if (s && (a[31] ^ b[31])) q = 32'd0 - q;
        if (s && a[31]) r = 32'd0 - r;
        return {r, q};
    endfunction

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        repeat (2) @(negedge clk);
        checks++; if (result_o !== 64'd0) begin fails++; $display("FAIL reset_result got=%h exp=0", result_o); end
        checks++; if (ready_o !== 1'b0) begin fails++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
        checks++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        checks++; if (stallreq_o !== 1'b0) begin fails++; $display("FAIL reset_stallreq got=%b exp=0", stallreq_o); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_divu_basic();
        logic [63:0] res; int lat, st, bz;
        run_div(1'b0, 32'd100, 32'd7, res, lat, st, bz);
        checks++; if (lat !== 33) begin fails++; $display("FAIL divu_latency got=%0d exp=33", lat); end
        checks++; if (st !== 33) begin fails++; $display("FAIL divu_stall_cycles got=%0d exp=33", st); end
        checks++; if (res !== {32'd2, 32'd14}) begin fails++; $display("FAIL divu_100_7 got=%h exp=%h", res, {32'd2, 32'd14}); end
        checks++; if (stallreq_o !== 1'b0) begin fails++; $display("FAIL divu_stall_at_ready got=%b exp=0", stallreq_o); end
        release_start();
    endtask

    task automatic test_signed();
        logic        s  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] a  [4] = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] b  [4] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1};
        logic [63:0] ex [4] = '{{32'hFFFFFFFF, 32'hFFFFFFFD}, {32'h1, 32'hFFFFFFFD},
                                {32'h0, 32'h80000000}, {32'h0, 32'hFFFFFFFF}};
        logic [63:0] res; int lat, st, bz;
        for (int i = 0; i < 4; i++) begin
            run_div(s[i], a[i], b[i], res, lat, st, bz);
            checks++; if (res !== ex[i]) begin fails++; $display("FAIL signed_vec%0d got=%h exp=%h", i, res, ex[i]); end
            release_start();
        end
    endtask

    task automatic test_divzero();
        logic [63:0] res; int lat, st, bz;
        run_div(1'b0, 32'h1234, 32'd0, res, lat, st, bz);
        checks++; if (lat !== 2) begin fails++; $display("FAIL divzero_latency got=%0d exp=2", lat); end
        checks++; if (res !== 64'd0) begin fails++; $display("FAIL divzero_result got=%h exp=0", res); end
        checks++; if (bz !== 1) begin fails++; $display("FAIL divzero_busy_cycles got=%0d exp=1", bz); end
        release_start();
    endtask

    task automatic test_annul();
        logic [63:0] res; int lat, st, bz, seen;
        @(negedge clk);
        signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        repeat (11) @(negedge clk);
        checks++; if (busy_o !== 1'b1) begin fails++; $display("FAIL annul_busy_before got=%b exp=1", busy_o); end
        annul_i = 1'b1; start_i = 1'b0;
        #1;
        checks++; if (stallreq_o !== 1'b0) begin fails++; $display("FAIL annul_stallreq got=%b exp=0", stallreq_o); end
        @(negedge clk);
        annul_i = 1'b0;
        checks++; if (busy_o !== 1'b0) begin fails++; $display("FAIL annul_idle got busy=%b exp=0", busy_o); end
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (ready_o) seen++;
        end
        checks++; if (seen !== 0) begin fails++; $display("FAIL annul_no_ready got=%0d exp=0", seen); end
        run_div(1'b0, 32'd9, 32'd3, res, lat, st, bz);
        checks++; if (lat !== 33) begin fails++; $display("FAIL annul_next_latency got=%0d exp=33", lat); end
        checks++; if (res !== {32'd0, 32'd3}) begin fails++; $display("FAIL annul_next_9_3 got=%h exp=%h", res, {32'd0, 32'd3}); end
        release_start();
    endtask

    task automatic test_rst_mid();
        logic [63:0] res; int lat, st, bz;
        run_div(1'b0, 32'd77, 32'd5, res, lat, st, bz);
        release_start();
        @(negedge clk);
        opdata1_i = 32'd12345; opdata2_i = 32'd11; start_i = 1'b1;
        repeat (21) @(negedge clk);
        rst = 1'b1; start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({result_o, ready_o, busy_o, stallreq_o} !== 67'd0) begin
            fails++; $display("FAIL rst_mid_outputs got res=%h rdy=%b busy=%b stall=%b exp=all0",
                              result_o, ready_o, busy_o, stallreq_o);
        end
        run_div(1'b0, 32'd50, 32'd8, res, lat, st, bz);
        checks++; if (res !== {32'd2, 32'd6}) begin fails++; $display("FAIL rst_next_50_8 got=%h exp=%h", res, {32'd2, 32'd6}); end
        checks++; if (lat !== 33) begin fails++; $display("FAIL rst_next_latency got=%0d exp=33", lat); end
        release_start();
    endtask

    task automatic test_hold_and_random();
        logic [63:0] res; int lat, st, bz, bad;
        logic [31:0] a, b; logic s;
        run_div(1'b1, 32'hFFFFFF9C, 32'd7, res, lat, st, bz);
        checks++; if (res !== {32'hFFFFFFFE, 32'hFFFFFFF2}) begin fails++; $display("FAIL hold_value got=%h exp=%h", res, {32'hFFFFFFFE, 32'hFFFFFFF2}); end
        bad = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (ready_o !== 1'b1 || result_o !== res) bad++;
        end
        checks++; if (bad !== 0) begin fails++; $display("FAIL hold_stable bad_cycles=%0d exp=0", bad); end
        start_i = 1'b0;
        @(negedge clk);
        checks++; if ({ready_o, busy_o} !== 2'b00) begin fails++; $display("FAIL hold_release got rdy/busy=%b%b exp=00", ready_o, busy_o); end
        for (int i = 0; i < 10; i++) begin
            s = i[0];
            a = $urandom;
            b = (i < 5) ? 32'($urandom_range(1, 300)) : $urandom;
            if (b == 0) b = 32'd1;
            if (i == 9) b = 32'hFFFFFFFF;
            run_div(s, a, b, res, lat, st, bz);
            checks++; if (res !== model(s, a, b) || lat !== 33) begin
                fails++; $display("FAIL rand%0d s=%b a=%h b=%h got=%h lat=%0d exp=%h lat=33",
                                  i, s, a, b, res, lat, model(s, a, b));
            end
            release_start();
        end
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_signed();
        test_divzero();
        test_annul();
        test_rst_mid();
        test_hold_and_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
